// File: rtl/i2c_slave_rd16.sv
// I2C target at a fixed 7-bit address: reads return a 16-bit snapshot MSB byte first,
// writes are ACKed and each received byte is strobed out on rx_valid/rx_data.
module i2c_slave_rd16 #(
   parameter logic [6:0] SADR = 7'h10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_msb,
   input  logic [7:0] data_lsb,
   input  logic       scl_pad_i,
   input  logic       sda_pad_i,
   output logic       sda_pad_o,
   output logic       sda_padoen_o,
   output logic       busy,
   output logic       rd_done,
   output logic       rx_valid,
   output logic [7:0] rx_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_TX, S_TX_ACK, S_RX, S_RX_ACK, S_IGNORE
   } state_t;

   // [0],[1] synchronise the pad; [2] is the history flop used for edge detection
   logic [2:0]  scl_sr_q, sda_sr_q;
   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] buf_q, buf_d;
   logic        byte_idx_q, byte_idx_d;
   logic        rw_q, rw_d;
   logic        ack_ph_q, ack_ph_d;
   logic        oen_q, oen_d;
   logic        busy_q, busy_d;
   logic        rd_done_q, rd_done_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  rx_data_q, rx_data_d;

   logic scl_s, scl_h, sda_s, sda_h;
   logic scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] cur_byte, in_byte;

   always_ff @(posedge clk) begin
      scl_sr_q <= {scl_sr_q[1:0], scl_pad_i};
      sda_sr_q <= {sda_sr_q[1:0], sda_pad_i};
   end

   assign scl_s = scl_sr_q[1];
   assign scl_h = scl_sr_q[2];
   assign sda_s = sda_sr_q[1];
   assign sda_h = sda_sr_q[2];

   // START/STOP require SCL high in both samples so a simultaneous SCL/SDA change is ignored
   assign scl_rise  = scl_s & ~scl_h;
   assign scl_fall  = ~scl_s & scl_h;
   assign start_det = scl_s & scl_h & sda_h & ~sda_s;
   assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

   assign cur_byte = byte_idx_q ? buf_q[7:0] : buf_q[15:8];
   assign in_byte  = {shift_q[6:0], sda_s};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      buf_d      = buf_q;
      byte_idx_d = byte_idx_q;
      rw_d       = rw_q;
      ack_ph_d   = ack_ph_q;
      oen_d      = oen_q;
      busy_d     = busy_q;
      rd_done_d  = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;

      if (stop_det) begin
         state_d = S_IDLE;
         oen_d   = 1'b1;
         busy_d  = 1'b0;
      end else if (start_det) begin
         state_d   = S_ADDR;
         bit_cnt_d = 4'd0;
         oen_d     = 1'b1;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_ADDR: begin
               if (scl_rise) begin
                  shift_d   = in_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (in_byte[7:1] == SADR) begin
                        buf_d      = {data_msb, data_lsb};
                        byte_idx_d = 1'b0;
                        rw_d       = in_byte[0];
                        ack_ph_d   = 1'b0;
                        state_d    = S_ADDR_ACK;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ack_ph_q) begin
                     oen_d    = 1'b0;
                     busy_d   = 1'b1;
                     ack_ph_d = 1'b1;
                  end else if (rw_q) begin
                     oen_d     = cur_byte[7];
                     bit_cnt_d = 4'd1;
                     state_d   = S_TX;
                  end else begin
                     oen_d     = 1'b1;
                     bit_cnt_d = 4'd0;
                     state_d   = S_RX;
                  end
               end
            end
            S_TX: begin
               // bit_cnt counts bits already presented; index 7-n is ~n in three bits
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     oen_d   = 1'b1;
                     state_d = S_TX_ACK;
                  end else begin
                     oen_d     = cur_byte[~bit_cnt_q[2:0]];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            S_TX_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     byte_idx_d = ~byte_idx_q;
                     bit_cnt_d  = 4'd0;
                     state_d    = S_TX;
                  end else begin
                     rd_done_d = 1'b1;
                     busy_d    = 1'b0;
                     state_d   = S_IGNORE;
                  end
               end
            end
            S_RX: begin
               if (scl_rise) begin
                  shift_d   = in_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     rx_data_d  = in_byte;
                     rx_valid_d = 1'b1;
                     ack_ph_d   = 1'b0;
                     state_d    = S_RX_ACK;
                  end
               end
            end
            S_RX_ACK: begin
               if (scl_fall) begin
                  if (!ack_ph_q) begin
                     oen_d    = 1'b0;
                     ack_ph_d = 1'b1;
                  end else begin
                     oen_d     = 1'b1;
                     bit_cnt_d = 4'd0;
                     state_d   = S_RX;
                  end
               end
            end
            S_IGNORE: oen_d = 1'b1;
            default: begin
               state_d = S_IDLE;
               oen_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         buf_q      <= 16'h0000;
         byte_idx_q <= 1'b0;
         rw_q       <= 1'b0;
         ack_ph_q   <= 1'b0;
         oen_q      <= 1'b1;
         busy_q     <= 1'b0;
         rd_done_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         buf_q      <= buf_d;
         byte_idx_q <= byte_idx_d;
         rw_q       <= rw_d;
         ack_ph_q   <= ack_ph_d;
         oen_q      <= oen_d;
         busy_q     <= busy_d;
         rd_done_q  <= rd_done_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign sda_pad_o    = 1'b0;
   assign sda_padoen_o = oen_q;
   assign busy         = busy_q;
   assign rd_done      = rd_done_q;
   assign rx_valid     = rx_valid_q;
   assign rx_data      = rx_data_q;

endmodule
